// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit with HI/LO registers.
// Multiply ops hold busy for MUL_LAT cycles and divide ops for DIV_LAT cycles,
// then HI/LO commit in a single step and done pulses for one cycle.
// MTHI/MTLO write HI/LO directly, without going busy.
// cancel aborts an in-flight op and nothing is committed.
// Optional feature macro: MDU_MADD_EN enables MADD (op 6) and MSUB (op 7).
// These accumulate into {hi,lo}. Without the macro, ops 6/7 are ignored.
module mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

  logic             state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             is_mul;
  logic             is_div;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] res;
  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] q_u;
  logic [WIDTH-1:0] r_u;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Classify the incoming op; MADD/MSUB count as multiplies only when enabled.
  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (op == OP_MADD) || (op == OP_MSUB);
`endif
    is_div = (op == OP_DIV) || (op == OP_DIVU);
  end

  // Final result from the latched operands. It is only used on the commit edge.
  // So HI/LO never see an intermediate value.
  always_comb begin
    // Low 2W bits of the sign-extended product equal the signed product mod 2^2W.
    prod_s = {{WIDTH{a_reg[WIDTH-1]}}, a_reg} * {{WIDTH{b_reg[WIDTH-1]}}, b_reg};
    prod_u = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};

    // Signed divide goes through magnitudes. MIN/-1 naturally yields MIN rem 0.
    div_signed = (op_reg == OP_DIV);
    a_neg = div_signed & a_reg[WIDTH-1];
    b_neg = div_signed & b_reg[WIDTH-1];
    abs_a = a_neg ? -a_reg : a_reg;
    abs_b = b_neg ? -b_reg : b_reg;
    // Keep the divider away from a zero divisor; that case is overridden below.
    if (b_reg == '0) begin
      abs_b = {{(WIDTH-1){1'b0}}, 1'b1};
    end
    q_u  = abs_a / abs_b;
    r_u  = abs_a % abs_b;
    quot = (a_neg ^ b_neg) ? -q_u : q_u;
    rem  = a_neg ? -r_u : r_u;

    res = {hi_reg, lo_reg};
    case (op_reg)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b_reg == '0) begin
          res = {a_reg, {WIDTH{1'b1}}};
        end else begin
          res = {rem, quot};
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi_reg, lo_reg} + prod_s;
      OP_MSUB:  res = {hi_reg, lo_reg} - prod_s;
`endif
      default:  res = {hi_reg, lo_reg};
    endcase
  end

  // Control FSM, latency counter, operand latch and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start && !cancel) begin
            if (is_mul || is_div) begin
              op_reg    <= op;
              a_reg     <= d1;
              b_reg     <= d2;
              cnt_reg   <= is_div ? DIV_CNT : MUL_CNT;
              busy_reg  <= 1'b1;
              state_reg <= ST_RUN;
            end else if (op == OP_MTHI) begin
              hi_reg <= d1;
            end else if (op == OP_MTLO) begin
              lo_reg <= d1;
            end
          end
        end
        default: begin
          // start is ignored here; cancel beats the final commit.
          if (cancel) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (cnt_reg == '0) begin
            hi_reg    <= res[2*WIDTH-1:WIDTH];
            lo_reg    <= res[WIDTH-1:0];
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter: table of multi-cycle ops plus directed corner sequences.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  mdu_iter #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .d1(d1), .d2(d2),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue a multi-cycle op, count busy cycles with a bound, then check the commit.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    int n;
    start = 1'b1; op = o; d1 = a; d2 = b;
    step();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      chk({name, "_done_while_busy"}, {31'd0, done}, 32'd0);
      n++;
      step();
    end
    chk({name, "_busy_cycles"}, n, lat);
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    $display("op %s: d1=%h d2=%h busy=%0d hi=%h lo=%h", name, a, b, n, hi, lo);
    step();
    chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  // Single-edge MTHI/MTLO write.
  task automatic mt(input logic [2:0] o, input logic [31:0] a, input logic c);
    start = 1'b1; op = o; d1 = a; cancel = c;
    step();
    start = 1'b0; cancel = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"mult_neg",   3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{"multu",      3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{"div_neg",    3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{"divu_zero",  3'd3, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 10};
    vecs[4] = '{"div_ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{"divu",       3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       10};
    vecs[6] = '{"div_negdiv", 3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[7] = '{"mult_max",   3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[8] = '{"div_zero_s", 3'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 10};
    vecs[9] = '{"multu_max",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};

    rst = 1'b1; start = 1'b0; op = '0; d1 = '0; d2 = '0; cancel = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat);
    end

    // MTHI/MTLO direct writes; a cancelled MTHI is dropped.
    mt(3'd5, 32'd5, 1'b0);
    chk("mtlo_lo", lo, 32'd5);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    mt(3'd4, 32'h0000ABCD, 1'b0);
    chk("mthi_hi", hi, 32'h0000ABCD);
    chk("mthi_done", {31'd0, done}, 32'd0);
    mt(3'd4, 32'h12345678, 1'b1);
    chk("mthi_cancel_hi", hi, 32'h0000ABCD);
    $display("mt: hi=%h lo=%h", hi, lo);

    // MULT 4*4 cancelled on busy cycle 3; a start on busy cycle 1 is ignored.
    start = 1'b1; op = 3'd0; d1 = 32'd4; d2 = 32'd4;
    step();
    chk("cxl_busy1", {31'd0, busy}, 32'd1);
    op = 3'd5; d1 = 32'd99;
    step();
    start = 1'b0;
    step();
    chk("cxl_busy3", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cxl_busy_off", {31'd0, busy}, 32'd0);
    chk("cxl_done", {31'd0, done}, 32'd0);
    chk("cxl_lo", lo, 32'd5);
    chk("cxl_hi", hi, 32'h0000ABCD);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("cxl_no_late_done", {31'd0, done}, 32'd0);
    end
    chk("cxl_lo_late", lo, 32'd5);
    $display("cancel mid-run: busy=%0d done=%0d lo=%h", busy, done, lo);

    // Cancel coinciding with the final busy edge wins.
    start = 1'b1; op = 3'd0; d1 = 32'd4; d2 = 32'd4;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    chk("cxl_last_busy5", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cxl_last_busy", {31'd0, busy}, 32'd0);
    chk("cxl_last_done", {31'd0, done}, 32'd0);
    chk("cxl_last_lo", lo, 32'd5);
    $display("cancel on last edge: busy=%0d done=%0d lo=%h", busy, done, lo);

    // cancel in IDLE blocks a simultaneous start.
    start = 1'b1; op = 3'd0; d1 = 32'd4; d2 = 32'd4; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0;
    chk("cxl_idle_busy", {31'd0, busy}, 32'd0);
    $display("cancel in idle: busy=%0d", busy);

    // Reset in the middle of a divide discards it.
    start = 1'b1; op = 3'd3; d1 = 32'd50; d2 = 32'd5;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rst_mid_no_done", {31'd0, done}, 32'd0);
    end
    $display("reset mid-op: busy=%0d hi=%h lo=%h", busy, hi, lo);

    // Multiply-accumulate ops.
    mt(3'd4, 32'd0, 1'b0);
    mt(3'd5, 32'd10, 1'b0);
`ifdef MDU_MADD_EN
    run_op("madd", 3'd6, 32'd2, 32'd3, 32'd0, 32'd16, 5);
    run_op("msub", 3'd7, 32'd4, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFC, 5);
`else
    start = 1'b1; op = 3'd6; d1 = 32'd2; d2 = 32'd3;
    step();
    start = 1'b0;
    chk("madd_off_busy", {31'd0, busy}, 32'd0);
    step(); step();
    chk("madd_off_done", {31'd0, done}, 32'd0);
    chk("madd_off_lo", lo, 32'd10);
    chk("madd_off_hi", hi, 32'd0);
    start = 1'b1; op = 3'd7;
    step();
    start = 1'b0;
    chk("msub_off_busy", {31'd0, busy}, 32'd0);
    chk("msub_off_lo", lo, 32'd10);
    $display("madd disabled: busy=%0d lo=%h", busy, lo);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
